nexys4_input_conditioner: RTL and testbench
===========================================

// Module: nexys4_input_conditioner
// PURPOSE
//  Conditions raw Nexys4 board inputs (16 slide switches, 2 active-high push buttons) before they reach the SoC.
//  Synchronises inputs to Clock, debounces them, and emits one-cycle event pulses.
//  Sits between the board pins and nexys4_wrapper; the SoC's GPIO/AHB slave reads its outputs.
// PARAMETERS
//  NUM_SWITCHES     16      width of switch bus
//  NUM_BUTTONS      2       number of push buttons
//  DEBOUNCE_CYCLES  100000  consecutive stable cycles needed to accept a new level (1 ms at 100 MHz); >=1
//  SYNC_STAGES      2       synchroniser flops per input; >=2
// PORTS
//  Clock             in   1             system clock, all logic on rising edge
//  Reset             in   1             asynchronous, active-high reset
//  Switches          in   NUM_SWITCHES  raw switch pins, asynchronous
//  Buttons           in   NUM_BUTTONS   raw button pins, active high, asynchronous
//  Switches_Stable   out  NUM_SWITCHES  debounced switch value
//  Switches_Changed  out  1             1-cycle pulse when Switches_Stable updates
//  Buttons_Level     out  NUM_BUTTONS   debounced button levels
//  Buttons_Pressed   out  NUM_BUTTONS   per-button 1-cycle pulse on debounced 0->1
//  Buttons_Released  out  NUM_BUTTONS   per-button 1-cycle pulse on debounced 1->0 (only with macro)
// BEHAVIOUR
//  Reset: all sync flops, counters, Switches_Stable, Switches_Changed, Buttons_* = 0; FSMs to IDLE.
//    Reset is async assert, sync release; reset mid-debounce discards the count, no pulse.
//  Sync: each input bit passes through SYNC_STAGES flops; no logic between stages.
//  Debounce FSM (one per button, one for whole switch bus), states IDLE / QUALIFY:
//    IDLE: sync input == stable value; count = 0. On mismatch -> QUALIFY, count = 1.
//    QUALIFY: if sync input != candidate captured on entry -> reload candidate, count = 1.
//      If sync input == stable value -> IDLE, count = 0, no update.
//      When count == DEBOUNCE_CYCLES and input still == candidate -> stable <= candidate, pulse, -> IDLE.
//  Switch bus is qualified as one vector: any bit change restarts the count (multi-bit moves yield one event).
//  Counter width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
//  Latency (pin edge to output update): SYNC_STAGES + DEBOUNCE_CYCLES cycles; pulse aligned with the update cycle.
//  Pulses are exactly 1 cycle; a level held indefinitely produces no further pulses.
//  Buttons are independent: simultaneous presses produce simultaneous Buttons_Pressed bits.
//  Switches high at reset release: Switches_Stable updates after latency, Switches_Changed pulses once.
//  Glitch shorter than DEBOUNCE_CYCLES: no output change, no pulse.
// CONFIGURATION
//  NEXYS4_BUTTON_RELEASE_EN defined: Buttons_Released port present; pulses 1 cycle on debounced 1->0.
//  Not defined: port absent; release edges update Buttons_Level only.
// STRUCTURE
//  Package nexys4_io_pkg: typedef enum logic {IDLE, QUALIFY} debounce_state_t;
//    localparam DEFAULT_DEBOUNCE_CYCLES = 100000; localparam DEFAULT_SYNC_STAGES = 2.
//  Sub-module debounce_filter #(WIDTH, DEBOUNCE_CYCLES, SYNC_STAGES): sync + FSM + stable reg + rise/fall pulses.
//    Instantiated once with WIDTH=NUM_SWITCHES (rise|fall ORed into Changed); NUM_BUTTONS times with WIDTH=1.
//  Top level is instantiation and port wiring only.
// TESTING (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, 10 ns clock)
//  Reset with Switches=16'h0001 -> outputs 0 during reset; 10 cycles after release Switches_Stable=16'h0001, Changed 1 cycle.
//  Buttons[0] clean 0->1 held -> Buttons_Pressed[0] pulses once at cycle 10; Buttons_Level[0]=1; no repeat while held.
//  Buttons[1] bounces 1,0,1 (2 cycles each) then holds 1 -> single press pulse 10 cycles after last edge.
//  Switches 0->3, bit1 lags bit0 by 3 cycles -> one Changed pulse; Switches_Stable goes 0->3 directly.
//  5-cycle glitch on Buttons[0] -> no Buttons_Level or pulse change.
//  Reset asserted at count 5 of a press -> all cleared, no pulse. With macro: release -> Buttons_Released 1 cycle.

Source files
------------

// File: rtl/nexys4_io_pkg.sv
// Shared types and defaults for the Nexys4 board input conditioning path.
package nexys4_io_pkg;

  typedef enum logic {IDLE, QUALIFY} debounce_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/nexys4_input_conditioner_debounce_filter.sv
// Synchroniser, vector debounce FSM and registered rise/fall pulses for one input group.
module debounce_filter
  import nexys4_io_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  debounce_state_t  state;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Stage p0..pN: plain flop chain, no logic between stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign sync_s  = sync_p[SYNC_STAGES-1];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Debounce stage: cnt holds the number of consecutive samples equal to cand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      case (state)
        IDLE: begin
          if (sync_s != stable) begin
            if (DEBOUNCE_CYCLES == 1) begin
              stable <= sync_s;
              rise   <= sync_s & ~stable;
              fall   <= ~sync_s & stable;
            end else begin
              state <= QUALIFY;
              cand  <= sync_s;
              cnt   <= CNT_ONE;
            end
          end
        end
        QUALIFY: begin
          if (sync_s == stable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (sync_s != cand) begin
            cand <= sync_s;
            cnt  <= CNT_ONE;
          end else if (cnt_inc == CNT_MAX) begin
            stable <= cand;
            rise   <= cand & ~stable;
            fall   <= ~cand & stable;
            state  <= IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign changed = |(rise | fall);

endmodule

// File: rtl/nexys4_input_conditioner.sv
// Nexys4 switch/button conditioner: sync, debounce and event pulses.
// Define NEXYS4_BUTTON_RELEASE_EN to add the Buttons_Released pulse output.
module nexys4_input_conditioner
  import nexys4_io_pkg::*;
#(
  parameter int NUM_SWITCHES    = 16,
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_SWITCHES-1:0] Switches,
  input  logic [NUM_BUTTONS-1:0]  Buttons,
  output logic [NUM_SWITCHES-1:0] Switches_Stable,
  output logic                    Switches_Changed,
  output logic [NUM_BUTTONS-1:0]  Buttons_Level,
  output logic [NUM_BUTTONS-1:0]  Buttons_Pressed
`ifdef NEXYS4_BUTTON_RELEASE_EN
  ,
  output logic [NUM_BUTTONS-1:0]  Buttons_Released
`endif
);

  logic [NUM_SWITCHES-1:0] sw_rise_unused;
  logic [NUM_SWITCHES-1:0] sw_fall_unused;
  logic [NUM_BUTTONS-1:0]  btn_fall;
  logic [NUM_BUTTONS-1:0]  btn_changed_unused;

  // The switch bus qualifies as one vector so a multi-bit move is one event
  debounce_filter #(
    .WIDTH           (NUM_SWITCHES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_sw_filter (
    .clk     (Clock),
    .rst     (Reset),
    .din     (Switches),
    .stable  (Switches_Stable),
    .rise    (sw_rise_unused),
    .fall    (sw_fall_unused),
    .changed (Switches_Changed)
  );

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    debounce_filter #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_filter (
      .clk     (Clock),
      .rst     (Reset),
      .din     (Buttons[b]),
      .stable  (Buttons_Level[b]),
      .rise    (Buttons_Pressed[b]),
      .fall    (btn_fall[b]),
      .changed (btn_changed_unused[b])
    );
  end

`ifdef NEXYS4_BUTTON_RELEASE_EN
  assign Buttons_Released = btn_fall;
`else
  logic unused_btn_fall;
  assign unused_btn_fall = ^btn_fall;
`endif

endmodule

// File: tb/tb_nexys4_input_conditioner.sv
// Scoreboard bench for nexys4_input_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
module tb_nexys4_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [1:0]  btn;
  logic [15:0] sw_stable;
  logic        sw_changed;
  logic [1:0]  btn_level;
  logic [1:0]  btn_pressed;
  logic [1:0]  btn_released;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic        chg;
    logic [15:0] sw;
    logic [1:0]  prs;
    logic [1:0]  rls;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nexys4_input_conditioner #(
    .NUM_SWITCHES    (16),
    .NUM_BUTTONS     (2),
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2)
  ) dut (
    .Clock            (clk),
    .Reset            (rst),
    .Switches         (sw),
    .Buttons          (btn),
    .Switches_Stable  (sw_stable),
    .Switches_Changed (sw_changed),
    .Buttons_Level    (btn_level),
    .Buttons_Pressed  (btn_pressed)
`ifdef NEXYS4_BUTTON_RELEASE_EN
    ,
    .Buttons_Released (btn_released)
`endif
  );

`ifndef NEXYS4_BUTTON_RELEASE_EN
  assign btn_released = 2'b00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic chg, input logic [15:0] s,
                           input logic [1:0] p, input logic [1:0] r);
    ev_t e;
    e.cyc = c; e.chg = chg; e.sw = s; e.prs = p; e.rls = r;
    sb.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (sw_changed || (|btn_pressed) || (|btn_released)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d actual chg=%b pressed=%b released=%b required no pulse",
                   cyc, sw_changed, btn_pressed, btn_released);
        end else begin
          e = sb.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("sw_changed", {31'd0, sw_changed}, {31'd0, e.chg});
          check("sw_stable", {16'd0, sw_stable}, {16'd0, e.sw});
          check("btn_pressed", {30'd0, btn_pressed}, {30'd0, e.prs});
`ifdef NEXYS4_BUTTON_RELEASE_EN
          check("btn_released", {30'd0, btn_released}, {30'd0, e.rls});
`endif
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1; sw = 16'h0001; btn = 2'b00;
    tick(3);
    check("rst_sw_stable", {16'd0, sw_stable}, 32'd0);
    check("rst_sw_changed", {31'd0, sw_changed}, 32'd0);
    check("rst_btn_level", {30'd0, btn_level}, 32'd0);
    check("rst_btn_pressed", {30'd0, btn_pressed}, 32'd0);

    // Switch high through reset: one Changed pulse 10 cycles after release
    rst = 1'b0;
    expect_ev(cyc + 10, 1'b1, 16'h0001, 2'b00, 2'b00);
    tick(14);
    check("sw_after_reset", {16'd0, sw_stable}, 32'h1);

    // Clean press on button 0, held well beyond qualification
    btn = 2'b01;
    expect_ev(cyc + 10, 1'b0, 16'h0001, 2'b01, 2'b00);
    tick(30);
    check("btn0_level", {30'd0, btn_level}, 32'h1);

    // Bouncing button 1: 1,0,1 for 2 cycles each then held
    btn = 2'b11; tick(2);
    btn = 2'b01; tick(2);
    btn = 2'b11;
    expect_ev(cyc + 10, 1'b0, 16'h0001, 2'b10, 2'b00);
    tick(20);
    check("btn1_level", {30'd0, btn_level}, 32'h3);

    // Return switches to zero, then a skewed 0->3 move
    sw = 16'h0000;
    expect_ev(cyc + 10, 1'b1, 16'h0000, 2'b00, 2'b00);
    tick(15);
    sw = 16'h0001; tick(3);
    sw = 16'h0003;
    expect_ev(cyc + 10, 1'b1, 16'h0003, 2'b00, 2'b00);
    tick(15);
    check("sw_skewed", {16'd0, sw_stable}, 32'h3);

    // 5-cycle glitch low on button 0 is ignored
    btn = 2'b10; tick(5);
    btn = 2'b11; tick(20);
    check("glitch_level", {30'd0, btn_level}, 32'h3);

    // Release button 1
    btn = 2'b01;
`ifdef NEXYS4_BUTTON_RELEASE_EN
    expect_ev(cyc + 10, 1'b0, 16'h0003, 2'b00, 2'b10);
`endif
    tick(15);
    check("btn1_released_level", {30'd0, btn_level}, 32'h1);

    // Reset at count 5 of a button 1 press discards it
    btn = 2'b11;
    tick(7);
    rst = 1'b1;
    tick(2);
    check("midrst_sw_stable", {16'd0, sw_stable}, 32'd0);
    check("midrst_btn_level", {30'd0, btn_level}, 32'd0);
    check("midrst_pressed", {30'd0, btn_pressed}, 32'd0);
    rst = 1'b0;
    expect_ev(cyc + 10, 1'b1, 16'h0003, 2'b11, 2'b00);
    tick(20);
    check("final_btn_level", {30'd0, btn_level}, 32'h3);
    check("final_sw_stable", {16'd0, sw_stable}, 32'h3);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
